// File: rtl/conv_seq_fsm.sv
// ============================================================================
// Module   : conv_seq_fsm
// Brief    : Frame sequencer driving MCU read/write addresses, sop/eop/chblk
//            and the Conv valid strobe over one or more block passes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_seq_fsm #(
    parameter int NB_ADDRESS = 4,
    parameter int LATENCY    = 3,
    parameter int NB_BLK     = 4
) (
    input  logic                  CLK100MHZ,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_next_data,
    input  logic [NB_BLK-1:0]     i_nblk,
    output logic [NB_ADDRESS-1:0] o_RAddr,
    output logic [NB_ADDRESS-1:0] o_WAddr,
    output logic                  o_sop,
    output logic                  o_eop,
    output logic                  o_chblk,
    output logic                  o_valid,
    output logic [NB_BLK-1:0]     o_blk
);

    localparam int c_CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [NB_ADDRESS-1:0] c_ADDR_MAX  = '1;
    localparam logic [NB_ADDRESS-1:0] c_ADDR_ZERO = '0;
    localparam logic [NB_ADDRESS-1:0] c_ADDR_ONE  = {{(NB_ADDRESS-1){1'b0}}, 1'b1};
    localparam logic [NB_ADDRESS:0]   c_LAT       = (NB_ADDRESS+1)'(LATENCY);
    localparam logic [NB_BLK-1:0]     c_BLK_ONE   = {{(NB_BLK-1){1'b0}}, 1'b1};
    localparam logic [c_CNT_W-1:0]    c_CNT_ONE   = {{(c_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [c_CNT_W-1:0]    c_CNT_LAST  = c_CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_CHBLK = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [NB_ADDRESS-1:0]   raddr_q, raddr_d;
    logic [NB_ADDRESS-1:0]   waddr_q, waddr_d;
    logic [NB_BLK-1:0]       blk_q, blk_d;
    logic [c_CNT_W-1:0]      cnt_q, cnt_d;
    logic                    sop_q, sop_d;
    logic                    eop_q, eop_d;
    logic                    chblk_q, chblk_d;
    logic                    valid_q, valid_d;
    logic                    start_q;
    logic                    next_q;

    logic                    w_start_rise;
    logic                    w_next_rise;
    logic [NB_BLK-1:0]       w_nblk_eff;
    logic                    w_more_blk;

    assign w_start_rise = i_start & ~start_q;
    assign w_next_rise  = i_next_data & ~next_q;
    assign w_nblk_eff   = (i_nblk == '0) ? c_BLK_ONE : i_nblk;
    assign w_more_blk   = (({1'b0, blk_q} + {1'b0, c_BLK_ONE}) < {1'b0, w_nblk_eff});

    // Edge registers track the input levels even in reset, so a level held
    // high across reset release never looks like a fresh edge.
    always_ff @(posedge CLK100MHZ) begin
        start_q <= i_start;
        next_q  <= i_next_data;
        if (rst) begin
            state_q <= ST_IDLE;
            raddr_q <= '0;
            waddr_q <= '0;
            blk_q   <= '0;
            cnt_q   <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b1;
            chblk_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
            blk_q   <= blk_d;
            cnt_q   <= cnt_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            chblk_q <= chblk_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        raddr_d = raddr_q;
        waddr_d = waddr_q;
        blk_d   = blk_q;
        cnt_d   = cnt_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        chblk_d = 1'b0;
        valid_d = valid_q;

        case (state_q)
            ST_IDLE: begin
                sop_d   = 1'b0;
                eop_d   = 1'b1;
                valid_d = 1'b0;
                if (w_start_rise) begin
                    state_d = ST_RUN;
                    raddr_d = c_ADDR_ZERO;
                    waddr_d = c_ADDR_ZERO;
                    blk_d   = '0;
                    valid_d = 1'b1;
                    sop_d   = 1'b1;
                    eop_d   = 1'b0;
                end else if (w_next_rise) begin
                    raddr_d = raddr_q + c_ADDR_ONE;
                end
            end

            ST_RUN: begin
                // Write side trails reads by the pipeline depth: max(0, RAddr-LATENCY).
                waddr_d = ({1'b0, raddr_q} < c_LAT) ? c_ADDR_ZERO : (waddr_q + c_ADDR_ONE);
                if (raddr_q == c_ADDR_MAX) begin
                    state_d = ST_DRAIN;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    raddr_d = raddr_q + c_ADDR_ONE;
                end
            end

            ST_DRAIN: begin
                if (cnt_q == c_CNT_LAST) begin
                    raddr_d = c_ADDR_ZERO;
                    waddr_d = c_ADDR_ZERO;
                    sop_d   = 1'b0;
                    if (w_more_blk) begin
                        state_d = ST_CHBLK;
                        chblk_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        eop_d   = 1'b1;
                    end
                end else begin
                    cnt_d   = cnt_q + c_CNT_ONE;
                    waddr_d = waddr_q + c_ADDR_ONE;
                end
            end

            ST_CHBLK: begin
                state_d = ST_RUN;
                blk_d   = blk_q + c_BLK_ONE;
                raddr_d = c_ADDR_ZERO;
                waddr_d = c_ADDR_ZERO;
                valid_d = 1'b1;
                sop_d   = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_RAddr = raddr_q;
    assign o_WAddr = waddr_q;
    assign o_sop   = sop_q;
    assign o_eop   = eop_q;
    assign o_chblk = chblk_q;
    assign o_valid = valid_q;
    assign o_blk   = blk_q;

endmodule

`default_nettype wire
